// File: rtl/capture_readback_sequencer.sv
`default_nettype none
// ============================================================================
// capture_readback_sequencer
// Arms one PSRAM capture, waits for the fill, then reads words back and
// streams each one out as bytes, least-significant byte first.
// Rev 1.0
// ============================================================================
module capture_readback_sequencer #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 128,
  parameter int ADDR_STEP   = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] read_base_addr,
  input  logic [CNT_W-1:0]  read_count,
  output logic              cmd_record,
  output logic              cmd_read_request,
  output logic [ADDR_W-1:0] read_request_addr,
  input  logic [DATA_W-1:0] read_data_out,
  input  logic              read_data_valid,
  input  logic              done,
  input  logic              ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              capture_done,
  output logic              error_timeout
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] S_IDLE          = 4'd0;
  localparam logic [3:0] S_ARM           = 4'd1;
  localparam logic [3:0] S_RECORD        = 4'd2;
  localparam logic [3:0] S_WAIT_DONE     = 4'd3;
  localparam logic [3:0] S_RD_WAIT_READY = 4'd4;
  localparam logic [3:0] S_RD_REQ        = 4'd5;
  localparam logic [3:0] S_RD_WAIT_DATA  = 4'd6;
  localparam logic [3:0] S_SHIFT         = 4'd7;
  localparam logic [3:0] S_FINISH        = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;

  logic start_ok, tmr_expired, tx_fire, last_byte;

  assign start_ok    = (state_q == S_IDLE) && start && !abort;
  assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign tx_fire     = (state_q == S_SHIFT) && tx_ready;
  assign last_byte   = (idx_q == IDX_W'(NBYTES - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (start) state_d = S_ARM;
      S_ARM:           if (ready) state_d = S_RECORD;
      S_RECORD:        state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done)             state_d = (rem_q == '0) ? S_FINISH : S_RD_WAIT_READY;
        else if (tmr_expired) state_d = S_IDLE;
      end
      S_RD_WAIT_READY: if (ready) state_d = S_RD_REQ;
      S_RD_REQ:        state_d = S_RD_WAIT_DATA;
      S_RD_WAIT_DATA: begin
        if (read_data_valid)  state_d = S_SHIFT;
        else if (tmr_expired) state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (tx_ready && last_byte)
          state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_RD_WAIT_READY;
      end
      S_FINISH:        state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including an accepted start.
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    addr_d     = addr_q;
    req_addr_d = req_addr_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    err_d      = err_q;
    tmr_d      = '0;
    if (start_ok) begin
      addr_d = read_base_addr;
      rem_d  = read_count;
      err_d  = 1'b0;
    end
    if (state_q == S_WAIT_DONE || state_q == S_RD_WAIT_DATA) tmr_d = tmr_q + TMR_W'(1);
    if (!abort) begin
      if (((state_q == S_WAIT_DONE && !done) ||
           (state_q == S_RD_WAIT_DATA && !read_data_valid)) && tmr_expired)
        err_d = 1'b1;
      if (state_q == S_RD_WAIT_READY && ready) req_addr_d = addr_q;
      if (state_q == S_RD_WAIT_DATA && read_data_valid) begin
        shift_d = read_data_out;
        idx_d   = '0;
      end
      // Shifting right keeps the outgoing byte at [7:0], so byte idx is always the low byte.
      if (tx_fire) begin
        shift_d = shift_q >> 8;
        idx_d   = idx_q + IDX_W'(1);
        if (last_byte) begin
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          rem_d  = rem_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q     <= '0;
      req_addr_q <= '0;
      rem_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    cmd_record        = (state_q == S_RECORD);
    cmd_read_request  = (state_q == S_RD_REQ);
    read_request_addr = req_addr_q;
    tx_valid          = (state_q == S_SHIFT);
    tx_data           = (state_q == S_SHIFT) ? shift_q[7:0] : 8'h00;
    busy              = (state_q != S_IDLE);
    capture_done      = (state_q == S_FINISH);
    error_timeout     = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_readback_sequencer.sv
`default_nettype none
// Directed bench for capture_readback_sequencer with a small storage-controller responder.
module tb_capture_readback_sequencer;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         start = 1'b0, abort = 1'b0;
  logic [20:0]  read_base_addr = '0;
  logic [15:0]  read_count = '0;
  logic         cmd_record, cmd_read_request;
  logic [20:0]  read_request_addr;
  logic [127:0] read_data_out = '0;
  logic         read_data_valid = 1'b0, done = 1'b0, ready = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_ready = 1'b1;
  logic         busy, capture_done, error_timeout;

  capture_readback_sequencer #(
    .ADDR_W(21), .DATA_W(128), .ADDR_STEP(8), .CNT_W(16), .TIMEOUT_CYC(100)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .read_base_addr(read_base_addr), .read_count(read_count),
    .cmd_record(cmd_record), .cmd_read_request(cmd_read_request),
    .read_request_addr(read_request_addr), .read_data_out(read_data_out),
    .read_data_valid(read_data_valid), .done(done), .ready(ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .capture_done(capture_done), .error_timeout(error_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [20:0]  base;
    logic [15:0]  cnt;
    int           dly;
    bit           bp;
    logic [127:0] data;
    int           nreq;
    logic [20:0]  first;
    logic [20:0]  last;
  } vec_t;

  vec_t vecs[5];

  int errors = 0, checks = 0;
  int cyc = 0, st_cyc = 0, rec_cyc = 0, req_cyc = 0, err_cyc = 0;
  int n_rec = 0, n_req = 0, n_done = 0, shift_cyc = 0, stall_bad = 0;
  int done_tmr = 0, rd_tmr = 0, cur_dly = 1;
  bit bp = 1'b0, resp_en = 1'b1, stall_prev = 1'b0, err_prev = 1'b0;
  logic [7:0]   stall_data = '0;
  logic [127:0] cur_data = '0;
  logic [20:0]  req_q[$];
  logic [7:0]   byte_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clr_log();
    n_rec = 0; n_req = 0; n_done = 0; shift_cyc = 0; stall_bad = 0;
    req_q.delete();
    byte_q.delete();
  endtask

  // Responder drives inputs first, then logs what the DUT will see at the next posedge.
  initial forever begin
    @(negedge sys_clk);
    cyc++;
    done = 1'b0;
    read_data_valid = 1'b0;
    if (done_tmr > 0) begin
      done_tmr--;
      if (done_tmr == 0) done = 1'b1;
    end
    if (cmd_record) done_tmr = cur_dly;
    if (rd_tmr > 0) begin
      rd_tmr--;
      if (rd_tmr == 0) begin
        read_data_valid = 1'b1;
        read_data_out   = cur_data;
      end
    end
    if (cmd_read_request && resp_en) rd_tmr = 2;
    tx_ready = bp ? (tx_valid ? ~tx_ready : 1'b1) : 1'b1;

    if (cmd_record) begin n_rec++; rec_cyc = cyc; end
    if (cmd_read_request) begin n_req++; req_q.push_back(read_request_addr); req_cyc = cyc; end
    if (capture_done) n_done++;
    if (error_timeout && !err_prev) err_cyc = cyc;
    err_prev = error_timeout;
    if (tx_valid) begin
      shift_cyc++;
      if (stall_prev && tx_data !== stall_data) stall_bad++;
      if (tx_ready) byte_q.push_back(tx_data);
    end
    stall_prev = tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  task automatic issue_start(input logic [20:0] base, input logic [15:0] cnt);
    tick();
    start = 1'b1; read_base_addr = base; read_count = cnt; st_cyc = cyc;
    tick();
    start = 1'b0; read_base_addr = 21'h0ABCD; read_count = 16'hFFFF;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int bad;
    v = vecs[i];
    clr_log();
    cur_dly = v.dly; cur_data = v.data; bp = v.bp;
    issue_start(v.base, v.cnt);
    for (int k = 0; k < 3000 && n_done == 0; k++) tick();
    repeat (3) tick();
    chk($sformatf("v%0d rec_count", i), n_rec, 1);
    chk($sformatf("v%0d rec_latency", i), rec_cyc - st_cyc, 2);
    chk($sformatf("v%0d req_count", i), n_req, v.nreq);
    if (v.nreq > 0 && req_q.size() > 0) begin
      chk($sformatf("v%0d first_addr", i), req_q[0], v.first);
      chk($sformatf("v%0d last_addr", i), req_q[$], v.last);
    end
    chk($sformatf("v%0d byte_count", i), byte_q.size(), 16 * int'(v.cnt));
    bad = 0;
    foreach (byte_q[k]) if (byte_q[k] !== v.data[8*(k%16) +: 8]) bad++;
    chk($sformatf("v%0d byte_values", i), bad, 0);
    chk($sformatf("v%0d stall_hold", i), stall_bad, 0);
    if (v.bp) chk($sformatf("v%0d shift_cycles", i), shift_cyc, 32 * int'(v.cnt));
    chk($sformatf("v%0d capture_done", i), n_done, 1);
    chk($sformatf("v%0d busy_after", i), busy, 0);
    chk($sformatf("v%0d no_timeout", i), error_timeout, 0);
  endtask

  initial begin
    vecs[0] = '{21'h000000, 16'd2, 50, 1'b0, 128'h0F0E0D0C0B0A09080706050403020100, 2, 21'h000000, 21'h000008};
    vecs[1] = '{21'h1FFFF8, 16'd2, 5,  1'b0, 128'hDEADBEEF0123456789ABCDEFA5C35A3C, 2, 21'h1FFFF8, 21'h000000};
    vecs[2] = '{21'h000100, 16'd1, 3,  1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 1, 21'h000100, 21'h000100};
    vecs[3] = '{21'h000040, 16'd0, 4,  1'b0, 128'h0,                               0, 21'h000000, 21'h000000};
    vecs[4] = '{21'h001234, 16'd3, 1,  1'b0, 128'hDEADBEEF0123456789ABCDEFA5C35A3C, 3, 21'h001234, 21'h001244};

    repeat (3) tick();
    chk("reset_outputs", {cmd_record, cmd_read_request, read_request_addr, tx_data,
                          tx_valid, busy, capture_done, error_timeout}, 0);
    sys_rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Asynchronous reset while a byte is being presented.
    clr_log();
    cur_dly = 3; cur_data = vecs[2].data; bp = 1'b1;
    issue_start(21'h000200, 16'd1);
    for (int k = 0; k < 500 && !tx_valid; k++) tick();
    chk("rst_shift_reached", tx_valid, 1);
    sys_rst = 1'b1;
    #1;
    chk("rst_mid_shift_outputs", {cmd_record, cmd_read_request, read_request_addr, tx_data,
                                  tx_valid, busy, capture_done, error_timeout}, 0);
    tick();
    sys_rst = 1'b0;
    repeat (10) tick();
    run_vec(0);

    // Read data never returns: timeout fires 100 cycles after RD_WAIT_DATA entry.
    clr_log();
    resp_en = 1'b0; bp = 1'b0; cur_dly = 2;
    issue_start(21'h000000, 16'd1);
    for (int k = 0; k < 1000 && !error_timeout; k++) tick();
    repeat (5) tick();
    chk("timeout_set", error_timeout, 1);
    chk("timeout_latency", err_cyc - req_cyc, 101);
    chk("timeout_no_done", n_done, 0);
    chk("timeout_idle", busy, 0);
    chk("timeout_req_count", n_req, 1);
    clr_log();
    resp_en = 1'b1;
    issue_start(21'h000000, 16'd0);
    chk("timeout_cleared", error_timeout, 0);
    for (int k = 0; k < 200 && n_done == 0; k++) tick();
    chk("after_timeout_done", n_done, 1);

    // Start while busy is ignored; abort during WAIT_DONE returns to IDLE.
    clr_log();
    cur_dly = 200;
    issue_start(21'h000000, 16'd2);
    for (int k = 0; k < 50 && n_rec == 0; k++) tick();
    repeat (5) tick();
    start = 1'b1; read_count = 16'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("busy_start_ignored", n_rec, 1);
    chk("busy_during_wait", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    repeat (250) tick();
    chk("abort_no_req", n_req, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_no_rec", n_rec, 1);

    // Simultaneous start and abort in IDLE: abort wins.
    clr_log();
    cur_dly = 3;
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (10) tick();
    chk("start_abort_no_rec", n_rec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
